// File: rtl/spike_injector.sv
// Reads one tick's spike bitmap out of spike memory one word at a time.
// Each set bit is replayed, in ascending neuron order, as a four-phase AER event.
module spike_injector #(
    parameter int unsigned N   = 256,
    parameter int unsigned WPT = N / 32
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       start_i,
    input  logic [7:0]                 tick_i,
    input  logic                       next_tick_i,
    input  logic                       abort_i,
    output logic                       mem_req_o,
    output logic [8+$clog2(WPT)-1:0]   mem_addr_o,
    input  logic                       mem_rvalid_i,
    input  logic [31:0]                mem_rdata_i,
    output logic [7:0]                 aer_addr_o,
    output logic                       aer_req_o,
    input  logic                       aer_ack_i,
    output logic                       spikecore_done_o,
    output logic                       inference_done_o
);

    localparam int unsigned WLOG = $clog2(WPT);
    localparam int unsigned AW   = 8 + WLOG;
    localparam int unsigned WIW  = (WPT > 1) ? WLOG : 1;
    localparam int unsigned NW   = WIW + 5;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_WAITD, S_SCAN, S_REQ, S_ACK, S_DONE
    } state_t;

    state_t          r_state;
    logic [7:0]      r_tick_q;
    logic [WIW-1:0]  r_word_idx;
    logic [4:0]      r_bit_idx;
    logic [31:0]     r_word_q;
    logic            r_ack_pend;
    logic            r_mem_req;
    logic [AW-1:0]   r_mem_addr;
    logic            r_aer_req;
    logic [7:0]      r_aer_addr;
    logic            r_done;
    logic            r_inf_done;

    logic            w_last_bit;
    logic            w_last_word;
    logic            w_bit_set;
    logic            w_advance;
    logic            w_start_ok;
    logic [NW-1:0]   w_neuron;
    logic [WIW-1:0]  w_word_nx;

    assign w_last_bit  = (r_bit_idx == 5'd31);
    assign w_last_word = (r_word_idx == WIW'(WPT - 1));
    assign w_bit_set   = r_word_q[r_bit_idx];
    assign w_neuron    = {r_word_idx, r_bit_idx};
    assign w_word_nx   = r_word_idx + WIW'(1);
    // Move past the current bit: a clear bit in SCAN, or a finished handshake in ACK
    assign w_advance   = ((r_state == S_SCAN) && !w_bit_set) ||
                         ((r_state == S_ACK) && !aer_ack_i);
    // After an abort mid-handshake the core may still hold ack high; wait for it to drop
    assign w_start_ok  = !r_ack_pend || !aer_ack_i;

    function automatic logic [AW-1:0] f_addr(input logic [7:0] tick, input logic [WIW-1:0] word);
        return (AW'(tick) << WLOG) | AW'(word);
    endfunction

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_IDLE;
            r_tick_q   <= '0;
            r_word_idx <= '0;
            r_bit_idx  <= '0;
            r_word_q   <= '0;
            r_ack_pend <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_aer_req  <= 1'b0;
            r_aer_addr <= '0;
            r_done     <= 1'b0;
            r_inf_done <= 1'b0;
        end else begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_inf_done <= 1'b0;
            if (!aer_ack_i) begin
                r_ack_pend <= 1'b0;
            end

            if (abort_i) begin
                r_state    <= S_IDLE;
                r_aer_req  <= 1'b0;
                r_aer_addr <= '0;
                r_done     <= 1'b0;
                if ((r_state == S_REQ) || (r_state == S_ACK)) begin
                    r_ack_pend <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i && w_start_ok) begin
                            r_word_idx <= '0;
                            r_state    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_tick_q   <= tick_i;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= f_addr(tick_i, r_word_idx);
                        r_state    <= S_FETCH;
                    end
                    S_FETCH: r_state <= S_WAITD;
                    S_WAITD: begin
                        if (mem_rvalid_i) begin
                            r_word_q  <= mem_rdata_i;
                            r_bit_idx <= '0;
                            r_state   <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (w_bit_set) begin
                            r_aer_req  <= 1'b1;
                            r_aer_addr <= 8'(w_neuron);
                            r_state    <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (aer_ack_i) begin
                            r_aer_req  <= 1'b0;
                            r_aer_addr <= '0;
                            r_state    <= S_ACK;
                        end
                    end
                    S_ACK: r_state <= S_ACK;
                    S_DONE: begin
                        if (next_tick_i) begin
                            r_done <= 1'b0;
                            if (r_tick_q != 8'd0) begin
                                r_word_idx <= '0;
                                r_state    <= S_LOAD;
                            end else begin
                                r_inf_done <= 1'b1;
                                r_state    <= S_IDLE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase

                // Shared next-bit / next-word / end-of-tick step for SCAN and ACK
                if (w_advance) begin
                    if (!w_last_bit) begin
                        r_bit_idx <= r_bit_idx + 5'd1;
                        r_state   <= S_SCAN;
                    end else if (!w_last_word) begin
                        r_word_idx <= w_word_nx;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= f_addr(r_tick_q, w_word_nx);
                        r_state    <= S_FETCH;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
            end
        end
    end

    assign mem_req_o        = r_mem_req;
    assign mem_addr_o       = r_mem_addr;
    assign aer_req_o        = r_aer_req;
    assign aer_addr_o       = r_aer_addr;
    assign spikecore_done_o = r_done;
    assign inference_done_o = r_inf_done;

endmodule

// File: tb/tb_spike_injector.sv
// Directed bench for spike_injector: behavioural spike memory, AER responder and
// handshake monitor, with hand-computed fetch addresses and event orderings.
`timescale 1ns/1ps
module tb_spike_injector;

    localparam int unsigned N   = 256;
    localparam int unsigned WPT = 8;
    localparam int unsigned AW  = 11;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          start_i;
    logic [7:0]    tick_i;
    logic          next_tick_i;
    logic          abort_i;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_rvalid_i;
    logic [31:0]   mem_rdata_i;
    logic [7:0]    aer_addr_o;
    logic          aer_req_o;
    logic          aer_ack_i;
    logic          spikecore_done_o;
    logic          inference_done_o;

    spike_injector #(.N(N), .WPT(WPT)) dut (
        .CLK              (CLK),
        .RSTN             (RSTN),
        .start_i          (start_i),
        .tick_i           (tick_i),
        .next_tick_i      (next_tick_i),
        .abort_i          (abort_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .aer_addr_o       (aer_addr_o),
        .aer_req_o        (aer_req_o),
        .aer_ack_i        (aer_ack_i),
        .spikecore_done_o (spikecore_done_o),
        .inference_done_o (inference_done_o)
    );

    always #5 CLK = ~CLK;

    int            n_chk = 0;
    int            n_fail = 0;
    int            n_early = 0;
    int            n_unstable = 0;
    int            mem_lat = 2;
    int            ack_n = 0;
    logic [31:0]   mem [0:2047];
    logic [AW-1:0] fetch_q [$];
    logic [7:0]    ev_q [$];
    logic [AW-1:0] rsp_addr;
    logic          ack_mode = 1'b0;
    logic          ack_man = 1'b0;
    logic          ack_auto = 1'b0;
    logic          prev_req = 1'b0;
    logic          prev_ack = 1'b0;
    logic [7:0]    prev_addr = 8'd0;

    assign aer_ack_i = ack_mode ? ack_man : ack_auto;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_clk(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return spikecore_done_o;
            1:       return mem_req_o;
            default: return aer_req_o;
        endcase
    endfunction

    task automatic wait_hi(input int sel, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (probe(sel)) break;
            tick_clk(1);
        end
        chk(tag, 32'(probe(sel)), 32'd1);
    endtask

    task automatic pulse_start(input logic [7:0] t);
        tick_i  = t;
        start_i = 1'b1;
        tick_clk(1);
        start_i = 1'b0;
    endtask

    task automatic do_next_tick();
        next_tick_i = 1'b1;
        tick_clk(1);
        next_tick_i = 1'b0;
        tick_i      = tick_i - 8'd1;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_mem_req"},  32'(mem_req_o),        32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_o),       32'd0);
        chk({tag, "_aer_req"},  32'(aer_req_o),        32'd0);
        chk({tag, "_aer_addr"}, 32'(aer_addr_o),       32'd0);
        chk({tag, "_done"},     32'(spikecore_done_o), 32'd0);
        chk({tag, "_inf_done"}, 32'(inference_done_o), 32'd0);
    endtask

    // Spike memory: fixed read latency, logs every request address
    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (mem_req_o) begin
                fetch_q.push_back(mem_addr_o);
                rsp_addr = mem_addr_o;
                repeat (mem_lat) begin
                    @(posedge CLK);
                    #1;
                end
                mem_rdata_i  = mem[rsp_addr];
                mem_rvalid_i = 1'b1;
                @(posedge CLK);
                #1;
                mem_rvalid_i = 1'b0;
            end
        end
    end

    // AER core model: four-phase ack with varying delays (0..5 cycles)
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (aer_req_o && !ack_mode) begin
                ev_q.push_back(aer_addr_o);
                ack_n++;
                repeat ((ack_n + 4) % 6) begin
                    @(posedge CLK);
                    #1;
                end
                ack_auto = 1'b1;
                for (int i = 0; i < 50; i++) begin
                    @(posedge CLK);
                    #1;
                    if (!aer_req_o) break;
                end
                repeat ((ack_n + 2) % 6) begin
                    @(posedge CLK);
                    #1;
                end
                ack_auto = 1'b0;
            end
        end
    end

    // Handshake monitor: req may only fall after ack, addr must hold while req is up
    initial begin
        forever begin
            @(negedge CLK);
            if (prev_req && aer_req_o && (aer_addr_o != prev_addr)) n_unstable++;
            if (prev_req && !aer_req_o && !prev_ack && !ack_mode) n_early++;
            prev_req  = aer_req_o;
            prev_ack  = aer_ack_i;
            prev_addr = aer_addr_o;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int f0;
        int e0;
        logic [7:0] exp_ev [4];
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        start_i     = 1'b0;
        tick_i      = 8'd0;
        next_tick_i = 1'b0;
        abort_i     = 1'b0;
        RSTN        = 1'b0;
        tick_clk(2);
        chk_outs_zero("rst");
        RSTN = 1'b1;
        tick_clk(2);

        // Single spike on neuron 37 at tick 255
        mem[255*8 + 1] = 32'h0000_0020;
        f0 = fetch_q.size();
        e0 = ev_q.size();
        pulse_start(8'd255);
        wait_hi(0, 3000, "t1_done");
        chk("t1_nfetch", 32'(fetch_q.size() - f0), 32'd8);
        for (int i = 0; i < 8; i++)
            if (f0 + i < fetch_q.size())
                chk($sformatf("t1_addr%0d", i), 32'(fetch_q[f0 + i]), 32'h7F8 + 32'(i));
        chk("t1_nev", 32'(ev_q.size() - e0), 32'd1);
        if (e0 < ev_q.size()) chk("t1_ev", 32'(ev_q[e0]), 32'd37);
        tick_clk(5);
        chk("t1_done_held", 32'(spikecore_done_o), 32'd1);

        // Empty tick 254
        f0 = fetch_q.size();
        e0 = ev_q.size();
        do_next_tick();
        chk("t2_done_drop", 32'(spikecore_done_o), 32'd0);
        wait_hi(0, 3000, "t2_done");
        chk("t2_nfetch", 32'(fetch_q.size() - f0), 32'd8);
        for (int i = 0; i < 8; i++)
            if (f0 + i < fetch_q.size())
                chk($sformatf("t2_addr%0d", i), 32'(fetch_q[f0 + i]), 32'h7F0 + 32'(i));
        chk("t2_nev", 32'(ev_q.size() - e0), 32'd0);

        // Tick 253 with neurons 0, 31, 32, 255; a stray start mid-run is ignored
        mem[253*8 + 0] = 32'h8000_0001;
        mem[253*8 + 1] = 32'h0000_0001;
        mem[253*8 + 7] = 32'h8000_0000;
        exp_ev = '{8'd0, 8'd31, 8'd32, 8'd255};
        f0 = fetch_q.size();
        e0 = ev_q.size();
        do_next_tick();
        wait_hi(1, 20, "t3_first_fetch");
        pulse_start(tick_i);
        wait_hi(0, 3000, "t3_done");
        chk("t3_nfetch", 32'(fetch_q.size() - f0), 32'd8);
        chk("t3_nev", 32'(ev_q.size() - e0), 32'd4);
        for (int i = 0; i < 4; i++)
            if (e0 + i < ev_q.size())
                chk($sformatf("t3_ev%0d", i), 32'(ev_q[e0 + i]), 32'(exp_ev[i]));
        chk("t3_req_early_fall", 32'(n_early), 32'd0);
        chk("t3_addr_unstable", 32'(n_unstable), 32'd0);

        // Abort out of DONE, then run ticks 1 and 0 to inference end
        abort_i = 1'b1;
        tick_clk(1);
        abort_i = 1'b0;
        chk("t4_abort_done", 32'(spikecore_done_o), 32'd0);
        f0 = fetch_q.size();
        pulse_start(8'd1);
        wait_hi(0, 3000, "t4_tick1");
        if (f0 < fetch_q.size()) chk("t4_addr_t1", 32'(fetch_q[f0]), 32'h008);
        do_next_tick();
        wait_hi(0, 3000, "t4_tick0");
        chk("t4_nfetch", 32'(fetch_q.size() - f0), 32'd16);
        if (f0 + 8 < fetch_q.size()) chk("t4_addr_t0", 32'(fetch_q[f0 + 8]), 32'h000);
        next_tick_i = 1'b1;
        tick_clk(1);
        next_tick_i = 1'b0;
        chk("t4_inf_pulse", 32'(inference_done_o), 32'd1);
        chk("t4_done_low", 32'(spikecore_done_o), 32'd0);
        tick_clk(1);
        chk_outs_zero("t4_idle");
        f0 = fetch_q.size();
        tick_clk(10);
        chk("t4_stays_idle", 32'(fetch_q.size() - f0), 32'd0);

        // Abort while aer_req is high with ack held high
        mem[10*8] = 32'h0000_0008;
        ack_mode = 1'b1;
        ack_man  = 1'b0;
        f0 = fetch_q.size();
        pulse_start(8'd10);
        wait_hi(2, 200, "t5_req");
        chk("t5_addr", 32'(aer_addr_o), 32'd3);
        ack_man = 1'b1;
        abort_i = 1'b1;
        tick_clk(1);
        abort_i = 1'b0;
        chk("t5_req_drop", 32'(aer_req_o), 32'd0);
        chk("t5_done", 32'(spikecore_done_o), 32'd0);
        pulse_start(8'd10);
        tick_clk(5);
        chk("t5_start_blocked", 32'(fetch_q.size() - f0), 32'd1);
        chk("t5_no_req", 32'(aer_req_o), 32'd0);
        ack_man = 1'b0;
        tick_clk(1);
        pulse_start(8'd10);
        wait_hi(1, 20, "t5_restart");
        tick_clk(1);
        chk("t5_nfetch", 32'(fetch_q.size() - f0), 32'd2);
        if (f0 + 1 < fetch_q.size()) chk("t5_addr_re", 32'(fetch_q[f0 + 1]), 32'h050);
        wait_hi(2, 200, "t5_req_again");
        chk("t5_addr_again", 32'(aer_addr_o), 32'd3);
        abort_i = 1'b1;
        tick_clk(1);
        abort_i  = 1'b0;
        ack_mode = 1'b0;
        tick_clk(2);

        // Asynchronous reset during WAITD; late read data must be ignored
        mem[20*8] = 32'h0000_0001;
        mem_lat = 6;
        f0 = fetch_q.size();
        e0 = ev_q.size();
        pulse_start(8'd20);
        wait_hi(1, 20, "t6_fetch");
        chk("t6_fetch_addr", 32'(mem_addr_o), 32'h0A0);
        tick_clk(1);
        #2;
        RSTN = 1'b0;
        #1;
        chk_outs_zero("t6_rst");
        tick_clk(1);
        RSTN = 1'b1;
        tick_clk(12);
        chk("t6_nev", 32'(ev_q.size() - e0), 32'd0);
        chk("t6_nfetch", 32'(fetch_q.size() - f0), 32'd1);
        chk("t6_aer_req", 32'(aer_req_o), 32'd0);
        chk("t6_done", 32'(spikecore_done_o), 32'd0);
        mem_lat = 2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
